// File: rtl/pid_ctrl_param_if.sv
// pid_ctrl_param_if: sample/result bundle between the loop sequencer and
// the PID controller.
//   sample_valid  one-cycle strobe, capture input_num/set_num
//   input_num     measured value, signed
//   set_num       setpoint, signed
//   kp/ki/kd      unsigned fixed-point gains, quasi-static
//   i_clear       integrator / derivative-history clear
//   out_valid     one-cycle strobe, new result on output_num/sign/sat
//   output_num    saturated magnitude of the result
//   sign          1 = result negative
//   sat           1 = magnitude was clipped
interface pid_ctrl_param_if #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 8,
   parameter int GAIN_W = 8
);
   logic                     sample_valid;
   logic signed [IN_W-1:0]   input_num;
   logic signed [IN_W-1:0]   set_num;
   logic [GAIN_W-1:0]        kp;
   logic [GAIN_W-1:0]        ki;
   logic [GAIN_W-1:0]        kd;
   logic                     i_clear;
   logic                     out_valid;
   logic [OUT_W-1:0]         output_num;
   logic                     sign;
   logic                     sat;

   modport master (
      output sample_valid, input_num, set_num, kp, ki, kd, i_clear,
      input  out_valid, output_num, sign, sat
   );

   modport slave (
      input  sample_valid, input_num, set_num, kp, ki, kd, i_clear,
      output out_valid, output_num, sign, sat
   );
endinterface

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: three-stage pipelined PID controller with clamped,
// conditionally-integrating integrator and saturated sign/magnitude output.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pid_ctrl_param_if.slave: sample strobe, measured/set values, gains,
//        integrator clear in; out_valid, output_num, sign, sat out
// Latency: sample at edge T -> out_valid high for one cycle after edge T+2.
module pid_ctrl_param #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 8,
   parameter int GAIN_W = 8,
   parameter int FRAC   = 4,
   parameter int ACC_W  = 32,
   parameter int I_LIM  = 1 << 20
) (
   input  logic            clk,
   input  logic            rst,
   pid_ctrl_param_if.slave bus
);
   localparam int E_W   = IN_W + 1;
   localparam int D_W   = IN_W + 2;
   localparam int SUM_W = ACC_W + GAIN_W + 2;

   localparam logic signed [ACC_W:0] LIM_P = (ACC_W+1)'(I_LIM);
   localparam logic signed [ACC_W:0] LIM_N = -LIM_P;

   function automatic logic signed [ACC_W-1:0] clamp_integ(input logic signed [ACC_W:0] v);
      if (v > LIM_P)      return ACC_W'(LIM_P);
      else if (v < LIM_N) return ACC_W'(LIM_N);
      else                return ACC_W'(v);
   endfunction

   // Returns {sat, magnitude}; magnitude is all ones when clipped.
   function automatic logic [OUT_W:0] sat_mag(input logic signed [SUM_W-1:0] s);
      logic [SUM_W-1:0] m;
      m = s[SUM_W-1] ? $unsigned(-s) : $unsigned(s);
      if (|m[SUM_W-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
      return {1'b0, m[OUT_W-1:0]};
   endfunction

   logic signed [E_W-1:0]   err;
   logic signed [D_W-1:0]   errd;
   logic signed [ACC_W-1:0] integ;
   logic signed [ACC_W-1:0] integ_base;
   logic signed [ACC_W:0]   integ_sum;
   logic signed [E_W-1:0]   last_err;
   logic                    first_flag;
   logic                    frozen;

   logic signed [E_W-1:0]   err_p1;
   logic signed [D_W-1:0]   errd_p1;
   logic                    vld_p1;

   logic signed [SUM_W-1:0] p_term, i_term, d_term, sum_full, sum_shift;
   logic signed [SUM_W-1:0] sum_p2;
   logic                    vld_p2;

   logic [OUT_W-1:0]        mag_p3;
   logic                    sign_p3;
   logic                    sat_p3;
   logic                    vld_p3;

   // ---- stage 1: error, derivative, integrator update ----
   always_comb begin
      err        = E_W'(bus.input_num) - E_W'(bus.set_num);
      errd       = (first_flag || bus.i_clear) ? '0 : D_W'(err) - D_W'(last_err);
      integ_base = bus.i_clear ? '0 : integ;
      integ_sum  = (ACC_W+1)'(integ_base) + (ACC_W+1)'(err);
      // Only stop integrating while the output is pinned and the error would
      // push it further into saturation; a clear always accumulates.
      frozen     = !bus.i_clear && sat_p3 &&
                   ((!sign_p3 && !err[E_W-1] && (|err)) || (sign_p3 && err[E_W-1]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         integ      <= '0;
         last_err   <= '0;
         first_flag <= 1'b1;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= bus.sample_valid;
         if (bus.sample_valid) begin
            last_err   <= err;
            first_flag <= 1'b0;
            if (!frozen) integ <= clamp_integ(integ_sum);
         end else if (bus.i_clear) begin
            integ      <= '0;
            first_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.sample_valid) begin
         err_p1  <= err;
         errd_p1 <= errd;
      end
      if (vld_p1) sum_p2 <= sum_shift;
   end

   // ---- stage 2: full-width weighted sum, floor shift by FRAC ----
   always_comb begin
      p_term    = SUM_W'($signed({1'b0, bus.kp})) * SUM_W'(err_p1);
      i_term    = SUM_W'($signed({1'b0, bus.ki})) * SUM_W'(integ);
      d_term    = SUM_W'($signed({1'b0, bus.kd})) * SUM_W'(errd_p1);
      sum_full  = p_term + i_term + d_term;
      sum_shift = sum_full >>> FRAC;
   end

   // ---- stage 3: sign/magnitude output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         mag_p3  <= '0;
         sign_p3 <= 1'b0;
         sat_p3  <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         if (vld_p2) begin
            sign_p3          <= sum_p2[SUM_W-1];
            {sat_p3, mag_p3} <= sat_mag(sum_p2);
         end
      end
   end

   assign bus.out_valid  = vld_p3;
   assign bus.output_num = mag_p3;
   assign bus.sign       = sign_p3;
   assign bus.sat        = sat_p3;
endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed bench for pid_ctrl_param. Two instances share
// all stimulus: dut_a with the default integrator clamp, dut_b with I_LIM=100.
module tb_pid_ctrl_param;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_valid = 1'b0;
   logic signed [15:0] input_num = '0;
   logic signed [15:0] set_num = '0;
   logic [7:0]        kp = '0, ki = '0, kd = '0;
   logic              i_clear = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pid_ctrl_param_if #(.IN_W(16), .OUT_W(8), .GAIN_W(8)) ifa ();
   pid_ctrl_param_if #(.IN_W(16), .OUT_W(8), .GAIN_W(8)) ifb ();

   assign ifa.sample_valid = sample_valid;
   assign ifa.input_num    = input_num;
   assign ifa.set_num      = set_num;
   assign ifa.kp           = kp;
   assign ifa.ki           = ki;
   assign ifa.kd           = kd;
   assign ifa.i_clear      = i_clear;
   assign ifb.sample_valid = sample_valid;
   assign ifb.input_num    = input_num;
   assign ifb.set_num      = set_num;
   assign ifb.kp           = kp;
   assign ifb.ki           = ki;
   assign ifb.kd           = kd;
   assign ifb.i_clear      = i_clear;

   pid_ctrl_param dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   pid_ctrl_param #(.I_LIM(100)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
   endtask

   // One strobe, then check latency, result on both instances, single-cycle valid.
   task automatic run_sample(input string tag, input int in_v, input int set_v,
                             input int ma, input bit sa, input bit ta,
                             input int mb, input bit sb, input bit tb_);
      @(negedge clk);
      input_num    = 16'(in_v);
      set_num      = 16'(set_v);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check_val({tag, "_vld_t0"}, ifa.out_valid, 0);
      @(negedge clk);
      check_val({tag, "_vld_t1"}, ifa.out_valid, 0);
      @(negedge clk);
      check_val({tag, "_vld_a"},  ifa.out_valid, 1);
      check_val({tag, "_mag_a"},  ifa.output_num, ma);
      check_val({tag, "_sign_a"}, ifa.sign, sa);
      check_val({tag, "_sat_a"},  ifa.sat, ta);
      check_val({tag, "_vld_b"},  ifb.out_valid, 1);
      check_val({tag, "_mag_b"},  ifb.output_num, mb);
      check_val({tag, "_sign_b"}, ifb.sign, sb);
      check_val({tag, "_sat_b"},  ifb.sat, tb_);
      @(negedge clk);
      check_val({tag, "_vld_drop"}, ifa.out_valid, 0);
      check_val({tag, "_hold_a"},   ifa.output_num, ma);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_mag",  ifa.output_num, 0);
      check_val("rst_sign", ifa.sign, 0);
      check_val("rst_sat",  ifa.sat, 0);
      check_val("rst_vld",  ifa.out_valid, 0);

      // proportional: 2.0 * 10 = 20
      kp = 8'd32; ki = 8'd0; kd = 8'd0;
      run_sample("p_only", 100, 90, 20, 0, 0, 20, 0, 0);

      // negative saturation and exact-limit boundary
      kp = 8'd16;
      run_sample("neg_sat",  0, 300, 255, 1, 1, 255, 1, 1);
      run_sample("neg_edge", 0, 255, 255, 1, 0, 255, 1, 0);
      run_sample("zero",     5, 5,   0,   0, 0, 0,   0, 0);
      // gain 1/16: -1/16 floors to -1, +1/16 floors to 0
      kp = 8'd1;
      run_sample("floor_neg", 0, 1, 1, 1, 0, 1, 1, 0);
      run_sample("floor_pos", 1, 0, 0, 0, 0, 0, 0, 0);

      // derivative with first-sample suppression and clear
      do_reset();
      kp = 8'd0; ki = 8'd0; kd = 8'd16;
      run_sample("d_first", 5,  0, 0, 0, 0, 0, 0, 0);
      run_sample("d_step",  12, 0, 7, 0, 0, 7, 0, 0);
      pulse_clear();
      run_sample("d_clear", 20, 0, 0, 0, 0, 0, 0, 0);

      // integrator: dut_b clamps at 100, dut_a does not
      do_reset();
      kp = 8'd0; ki = 8'd16; kd = 8'd0;
      run_sample("i_1", 60, 0, 60,  0, 0, 60,  0, 0);
      run_sample("i_2", 60, 0, 120, 0, 0, 100, 0, 0);
      run_sample("i_3", 60, 0, 180, 0, 0, 100, 0, 0);
      run_sample("i_4", 0, 30, 150, 0, 0, 70,  0, 0);

      // anti-windup: second sample frozen while saturated positive
      do_reset();
      kp = 8'd16; ki = 8'd16; kd = 8'd0;
      run_sample("aw_1", 200, 0, 255, 0, 1, 255, 0, 1);
      run_sample("aw_2", 200, 0, 255, 0, 1, 255, 0, 1);
      run_sample("aw_3", 0, 50,  100, 0, 0, 0,   0, 0);

      // reset while a sample is in flight
      kd = 8'd16;
      @(negedge clk);
      input_num = 16'sd50; set_num = 16'sd0; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_mag",  ifa.output_num, 0);
      check_val("mid_rst_sign", ifa.sign, 0);
      check_val("mid_rst_sat",  ifa.sat, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("mid_rst_novld", ifa.out_valid, 0);
      end
      rst = 1'b0;
      // no derivative kick, integrator restarts from 0: (50 + 50 + 0) * 1.0
      run_sample("post_rst", 50, 0, 100, 0, 0, 100, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
